// File: rtl/uart_request_controller.sv
// Turns the UART receiver byte stream into validated two-byte sensor requests
// (command, then address), with an inter-byte timeout and a valid/ready output.
module uart_request_controller #(
  parameter int TIMEOUT_CYCLES = 43400,
  parameter int MAX_COMMAND    = 7,
  parameter int MAX_ADDRESS    = 31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       has_data,
  input  logic [7:0] data_received,
  input  logic       request_ready,
  output logic       request_valid,
  output logic [7:0] request_command,
  output logic [7:0] request_address,
  output logic       error,
  output logic [1:0] error_code,
  output logic       overrun,
  output logic [2:0] debug_state
);

  // A one-cycle timeout still needs a one-bit counter.
  localparam int              COUNTER_WIDTH  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [COUNTER_WIDTH-1:0] TIMEOUT_LAST = COUNTER_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]      MAX_COMMAND_BYTE = 8'(MAX_COMMAND);
  localparam logic [7:0]      MAX_ADDRESS_BYTE = 8'(MAX_ADDRESS);

  localparam logic [1:0] CAUSE_BAD_COMMAND = 2'd1;
  localparam logic [1:0] CAUSE_BAD_ADDRESS = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT     = 2'd3;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WAIT_ADDRESS = 3'd1,
    VALIDATE     = 3'd2,
    DISPATCH     = 3'd3,
    ERROR        = 3'd4
  } state_t;

  state_t                    state_reg;
  state_t                    state_next;
  logic [7:0]                command_reg;
  logic [7:0]                address_reg;
  logic [COUNTER_WIDTH-1:0]  counter_reg;
  logic [1:0]                error_code_reg;
  logic [1:0]                error_code_next;
  logic                      overrun_reg;
  logic [2:0]                debug_state_reg;
  logic                      latch_command;
  logic                      latch_address;
  logic                      timeout_hit;
  logic                      busy;

  assign timeout_hit = (counter_reg == TIMEOUT_LAST);
  assign busy        = (state_reg == VALIDATE) || (state_reg == DISPATCH) || (state_reg == ERROR);

  always_comb begin
    state_next      = state_reg;
    error_code_next = error_code_reg;
    latch_command   = 1'b0;
    latch_address   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (has_data) begin
          latch_command = 1'b1;
          state_next    = WAIT_ADDRESS;
        end
      end
      WAIT_ADDRESS: begin
        // An address byte on the very last allowed cycle beats the timeout.
        if (has_data) begin
          latch_address = 1'b1;
          state_next    = VALIDATE;
        end else if (timeout_hit) begin
          state_next      = ERROR;
          error_code_next = CAUSE_TIMEOUT;
        end
      end
      VALIDATE: begin
        if (command_reg > MAX_COMMAND_BYTE) begin
          state_next      = ERROR;
          error_code_next = CAUSE_BAD_COMMAND;
        end else if (address_reg > MAX_ADDRESS_BYTE) begin
          state_next      = ERROR;
          error_code_next = CAUSE_BAD_ADDRESS;
        end else begin
          state_next = DISPATCH;
        end
      end
      DISPATCH: begin
        if (request_ready) begin
          state_next = IDLE;
        end
      end
      ERROR: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg       <= IDLE;
      command_reg     <= 8'd0;
      address_reg     <= 8'd0;
      error_code_reg  <= 2'd0;
      overrun_reg     <= 1'b0;
      debug_state_reg <= 3'd0;
    end else begin
      state_reg       <= state_next;
      error_code_reg  <= error_code_next;
      overrun_reg     <= has_data && busy;
      debug_state_reg <= state_reg;
      if (latch_command) begin
        command_reg <= data_received;
      end
      if (latch_address) begin
        address_reg <= data_received;
      end
    end
  end

  // Held at zero outside WAIT_ADDRESS, so every entry starts from zero; saturates.
  always_ff @(posedge clock) begin
    if (reset || (state_reg != WAIT_ADDRESS)) begin
      counter_reg <= '0;
    end else if (!timeout_hit) begin
      counter_reg <= counter_reg + 1'b1;
    end
  end

  assign request_valid   = (state_reg == DISPATCH);
  assign request_command = command_reg;
  assign request_address = address_reg;
  assign error           = (state_reg == ERROR);
  assign error_code      = error_code_reg;
  assign overrun         = overrun_reg;
  assign debug_state     = debug_state_reg;

endmodule
